// File: rtl/cnn_mem_server.sv
// Memory server for a 3x3 CNN core: image and filter stores loaded by the
// host, a start handshake with the core, capture of the result stream into
// an output buffer, and run status (done, overflow, cycle count).
module cnn_mem_server #(
  parameter int IMG_DEPTH = 4356,
  parameter int FLT_DEPTH = 9,
  parameter int OUT_DEPTH = 4096
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        host_we,
  input  logic        host_sel,
  input  logic [12:0] host_addr,
  input  logic [7:0]  host_wdata,
  input  logic        host_start,
  output logic        image_ready,
  input  logic        image_rden_i,
  input  logic [12:0] image_addr_i,
  output logic [7:0]  image_o,
  output logic        image_valid_o,
  input  logic        filter_rden_i,
  input  logic [3:0]  filter_addr_i,
  output logic [7:0]  filter_o,
  output logic        filter_valid_o,
  input  logic        cnn_valid_i,
  input  logic [7:0]  cnn_data_i,
  input  logic        host_rd_en,
  input  logic [11:0] host_rd_addr,
  output logic [7:0]  host_rdata,
  output logic        host_rvalid,
  output logic        done_o,
  output logic        overflow_o,
  output logic [20:0] latency_o
);

  localparam int IA_W = $clog2(IMG_DEPTH);
  localparam int FA_W = $clog2(FLT_DEPTH);
  localparam int OA_W = $clog2(OUT_DEPTH);
  localparam logic [12:0] OUT_LIM = 13'(OUT_DEPTH);

  typedef enum logic [1:0] {IDLE, PULSE, RUN, DONE} state_t;

  state_t      state_q, state_d;
  logic [12:0] out_cnt;

  logic [7:0] img_mem [0:IMG_DEPTH-1];
  logic [7:0] flt_mem [0:FLT_DEPTH-1];
  logic [7:0] out_mem [0:OUT_DEPTH-1];

  logic host_ok;
  logic start_acc;
  logic img_wr;
  logic flt_wr;
  logic capture;
  logic ovf_hit;
  logic img_in_rng;
  logic flt_in_rng;

  // Latency counter stops at all ones instead of wrapping.
  function automatic logic [20:0] sat_inc(input logic [20:0] v);
    return (&v) ? v : v + 21'd1;
  endfunction

  // Decode of host write acceptance, capture and overflow conditions.
  always_comb begin
    host_ok    = (state_q == IDLE) || (state_q == DONE);
    start_acc  = host_ok && host_start;
    img_wr     = host_we && host_ok && !host_sel &&
                 (32'(host_addr) < 32'(IMG_DEPTH));
    flt_wr     = host_we && host_ok && host_sel &&
                 (32'(host_addr) < 32'(FLT_DEPTH));
    capture    = (state_q == RUN) && cnn_valid_i && (out_cnt < OUT_LIM);
    ovf_hit    = ((state_q == RUN) || (state_q == DONE)) && cnn_valid_i &&
                 (out_cnt == OUT_LIM);
    img_in_rng = 32'(image_addr_i) < 32'(IMG_DEPTH);
    flt_in_rng = 32'(filter_addr_i) < 32'(FLT_DEPTH);
  end

  // Run-control state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: the final capture moves RUN to DONE on the same edge.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start_acc) state_d = PULSE;
      PULSE: state_d = RUN;
      RUN:   if (capture && (out_cnt == OUT_LIM - 13'd1)) state_d = DONE;
      DONE:  if (start_acc) state_d = PULSE;
      default: state_d = IDLE;
    endcase
  end

  assign image_ready = (state_q == PULSE);

  // Run status: cleared when a run starts, updated by captures and time.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_cnt    <= '0;
      latency_o  <= '0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else if (state_d == PULSE && state_q != PULSE) begin
      out_cnt    <= '0;
      latency_o  <= '0;
      done_o     <= 1'b0;
      overflow_o <= 1'b0;
    end else begin
      if (capture) out_cnt <= out_cnt + 13'd1;
      if (state_q == PULSE || state_q == RUN) latency_o <= sat_inc(latency_o);
      if (ovf_hit) overflow_o <= 1'b1;
      if (state_d == DONE && state_q != DONE) done_o <= 1'b1;
    end
  end

  // Storage writes; contents survive reset.
  always_ff @(posedge clk) begin
    if (img_wr)  img_mem[host_addr[IA_W-1:0]] <= host_wdata;
    if (flt_wr)  flt_mem[host_addr[FA_W-1:0]] <= host_wdata;
    if (capture) out_mem[out_cnt[OA_W-1:0]]   <= cnn_data_i;
  end

  // Image read port: one-cycle latency, out-of-range reads return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      image_o       <= 8'h00;
      image_valid_o <= 1'b0;
    end else begin
      image_valid_o <= image_rden_i;
      if (image_rden_i)
        image_o <= img_in_rng ? img_mem[image_addr_i[IA_W-1:0]] : 8'h00;
    end
  end

  // Filter read port: same behaviour as the image port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filter_o       <= 8'h00;
      filter_valid_o <= 1'b0;
    end else begin
      filter_valid_o <= filter_rden_i;
      if (filter_rden_i)
        filter_o <= flt_in_rng ? flt_mem[filter_addr_i[FA_W-1:0]] : 8'h00;
    end
  end

  // Host readback of the captured results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      host_rdata  <= 8'h00;
      host_rvalid <= 1'b0;
    end else begin
      host_rvalid <= host_rd_en;
      if (host_rd_en) host_rdata <= out_mem[host_rd_addr[OA_W-1:0]];
    end
  end

endmodule

// File: tb/tb_cnn_mem_server.sv
// Self-checking bench for cnn_mem_server: table-driven read vectors, random
// host/core traffic against array models, and full run sequences.
module tb_cnn_mem_server;

  localparam int IMG = 4356;
  localparam int FLT = 9;
  localparam int OUTD = 4096;

  logic        clk;
  logic        rst_n;
  logic        host_we, host_sel, host_start;
  logic [12:0] host_addr;
  logic [7:0]  host_wdata;
  logic        image_ready;
  logic        image_rden_i;
  logic [12:0] image_addr_i;
  logic [7:0]  image_o;
  logic        image_valid_o;
  logic        filter_rden_i;
  logic [3:0]  filter_addr_i;
  logic [7:0]  filter_o;
  logic        filter_valid_o;
  logic        cnn_valid_i;
  logic [7:0]  cnn_data_i;
  logic        host_rd_en;
  logic [11:0] host_rd_addr;
  logic [7:0]  host_rdata;
  logic        host_rvalid;
  logic        done_o, overflow_o;
  logic [20:0] latency_o;

  cnn_mem_server dut (
    .clk(clk), .rst_n(rst_n),
    .host_we(host_we), .host_sel(host_sel), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_start(host_start),
    .image_ready(image_ready),
    .image_rden_i(image_rden_i), .image_addr_i(image_addr_i),
    .image_o(image_o), .image_valid_o(image_valid_o),
    .filter_rden_i(filter_rden_i), .filter_addr_i(filter_addr_i),
    .filter_o(filter_o), .filter_valid_o(filter_valid_o),
    .cnn_valid_i(cnn_valid_i), .cnn_data_i(cnn_data_i),
    .host_rd_en(host_rd_en), .host_rd_addr(host_rd_addr),
    .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .done_o(done_o), .overflow_o(overflow_o), .latency_o(latency_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] img_m [0:IMG-1];
  logic [7:0] flt_m [0:FLT-1];
  logic [7:0] out_m [0:OUTD-1];
  logic [7:0] exp_img, exp_flt;

  typedef struct {
    bit         sel;
    int         addr;
    logic [7:0] exp;
  } rd_vec_t;

  rd_vec_t tbl [12];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic host_write(input bit sel, input int addr, input logic [7:0] d);
    host_we = 1'b1; host_sel = sel; host_addr = 13'(addr); host_wdata = d;
    tick();
    host_we = 1'b0;
  endtask

  task automatic readback(input string name, input int addr, input logic [7:0] exp);
    host_rd_en = 1'b1; host_rd_addr = 12'(addr);
    tick();
    host_rd_en = 1'b0;
    chk({name, "_data"}, host_rdata, exp);
    chk({name, "_vld"}, host_rvalid, 1'b1);
  endtask

  task automatic img_read(input string name, input int addr, input logic [7:0] exp);
    image_rden_i = 1'b1; image_addr_i = 13'(addr);
    tick();
    image_rden_i = 1'b0;
    chk(name, image_o, exp);
    exp_img = exp;
  endtask

  task automatic check_reset_values();
    chk("rst_ready", image_ready, 1'b0);
    chk("rst_ivld", image_valid_o, 1'b0);
    chk("rst_fvld", filter_valid_o, 1'b0);
    chk("rst_rvld", host_rvalid, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_ovf", overflow_o, 1'b0);
    chk("rst_img", image_o, 8'h00);
    chk("rst_flt", filter_o, 8'h00);
    chk("rst_rdata", host_rdata, 8'h00);
    chk("rst_lat", latency_o, 21'd0);
  endtask

  // Issues an accepted start and checks the single-cycle pulse.
  task automatic start_run(input string name);
    host_start = 1'b1;
    tick();
    host_start = 1'b0;
    chk({name, "_pulse_hi"}, image_ready, 1'b1);
    chk({name, "_done_clr"}, done_o, 1'b0);
    tick();
    chk({name, "_pulse_lo"}, image_ready, 1'b0);
  endtask

  // Drives n back-to-back result bytes; returns how many start pulses appeared.
  task automatic captures(input int n, input bit rnd, input bit poke, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      cnn_valid_i = 1'b1;
      cnn_data_i  = rnd ? 8'($urandom) : 8'(i);
      out_m[i]    = cnn_data_i;
      host_start  = poke && (i == 10);
      host_we     = poke && (i == 20);
      host_sel    = 1'b0;
      host_addr   = 13'd5;
      host_wdata  = 8'hEE;
      tick();
      if (image_ready) pulses++;
    end
    cnn_valid_i = 1'b0;
    host_start  = 1'b0;
    host_we     = 1'b0;
  endtask

  initial begin
    int pulses;
    int a;
    bit we, sel, ir, fr;
    int wa, ia, fa;
    logic [7:0] wd;

    rst_n = 1'b0;
    host_we = 0; host_sel = 0; host_addr = '0; host_wdata = '0; host_start = 0;
    image_rden_i = 0; image_addr_i = '0; filter_rden_i = 0; filter_addr_i = '0;
    cnn_valid_i = 0; cnn_data_i = '0; host_rd_en = 0; host_rd_addr = '0;
    #1;
    check_reset_values();
    @(posedge clk); @(posedge clk); #3;
    rst_n = 1'b1;
    tick();
    chk("idle_no_pulse", image_ready, 1'b0);

    // Load image with k[7:0] and filter with 1..9; out-of-range writes dropped.
    for (int k = 0; k < IMG; k++) begin
      host_write(1'b0, k, 8'(k));
      img_m[k] = 8'(k);
    end
    for (int k = 0; k < FLT; k++) begin
      host_write(1'b1, k, 8'(k + 1));
      flt_m[k] = 8'(k + 1);
    end
    host_write(1'b1, 10, 8'h55);
    host_write(1'b0, 4400, 8'h55);

    tbl[0]  = '{1'b0, 'h0A5, 8'hA5};
    tbl[1]  = '{1'b1, 8,     8'h09};
    tbl[2]  = '{1'b0, 0,     8'h00};
    tbl[3]  = '{1'b0, 4355,  8'h03};
    tbl[4]  = '{1'b0, 4400,  8'h00};
    tbl[5]  = '{1'b0, 8191,  8'h00};
    tbl[6]  = '{1'b0, 300,   8'h2C};
    tbl[7]  = '{1'b1, 0,     8'h01};
    tbl[8]  = '{1'b1, 4,     8'h05};
    tbl[9]  = '{1'b1, 9,     8'h00};
    tbl[10] = '{1'b1, 15,    8'h00};
    tbl[11] = '{1'b0, 4356,  8'h00};

    for (int i = 0; i < 12; i++) begin
      if (!tbl[i].sel) begin
        image_rden_i = 1'b1; image_addr_i = 13'(tbl[i].addr);
      end else begin
        filter_rden_i = 1'b1; filter_addr_i = 4'(tbl[i].addr);
      end
      tick();
      image_rden_i = 1'b0; filter_rden_i = 1'b0;
      if (!tbl[i].sel) begin
        chk("tbl_img_data", image_o, tbl[i].exp);
        chk("tbl_img_vld", image_valid_o, 1'b1);
        exp_img = tbl[i].exp;
      end else begin
        chk("tbl_flt_data", filter_o, tbl[i].exp);
        chk("tbl_flt_vld", filter_valid_o, 1'b1);
        exp_flt = tbl[i].exp;
      end
      tick();
      chk("tbl_img_vld_drop", image_valid_o, 1'b0);
      chk("tbl_flt_vld_drop", filter_valid_o, 1'b0);
      chk("tbl_img_hold", image_o, exp_img);
      chk("tbl_flt_hold", filter_o, exp_flt);
    end

    // Random host writes mixed with core reads; reads see pre-write data.
    for (int n = 0; n < 300; n++) begin
      we  = 1'($urandom);
      sel = 1'($urandom);
      wa  = sel ? int'($urandom_range(0, 12)) : int'($urandom_range(0, 4500));
      wd  = 8'($urandom);
      ir  = 1'($urandom);
      fr  = 1'($urandom);
      ia  = (n % 7 == 0) ? wa : int'($urandom_range(0, 4500));
      fa  = (n % 5 == 0) ? (wa & 15) : int'($urandom_range(0, 15));
      if (ir) exp_img = (ia < IMG) ? img_m[ia] : 8'h00;
      if (fr) exp_flt = (fa < FLT) ? flt_m[fa] : 8'h00;
      if (we && !sel && wa < IMG) img_m[wa] = wd;
      if (we && sel && wa < FLT)  flt_m[wa] = wd;
      host_we = we; host_sel = sel; host_addr = 13'(wa); host_wdata = wd;
      image_rden_i = ir; image_addr_i = 13'(ia);
      filter_rden_i = fr; filter_addr_i = 4'(fa);
      tick();
      host_we = 0; image_rden_i = 0; filter_rden_i = 0;
      chk("rnd_img_data", image_o, exp_img);
      chk("rnd_img_vld", image_valid_o, ir);
      chk("rnd_flt_data", filter_o, exp_flt);
      chk("rnd_flt_vld", filter_valid_o, fr);
    end

    // Same-cycle write and read at one address returns the old byte.
    host_we = 1; host_sel = 0; host_addr = 13'h10; host_wdata = 8'hC3;
    image_rden_i = 1; image_addr_i = 13'h10;
    tick();
    host_we = 0; image_rden_i = 0;
    chk("coll_old", image_o, img_m['h10]);
    img_m['h10] = 8'hC3;
    img_read("coll_new", 'h10, 8'hC3);

    // Full run with a stray start and a dropped write in the middle.
    start_run("run1");
    captures(OUTD, 1'b0, 1'b1, pulses);
    chk("run1_no_restart", pulses, 0);
    chk("run1_done", done_o, 1'b1);
    chk("run1_lat", latency_o, 21'd4097);
    chk("run1_ovf", overflow_o, 1'b0);
    readback("run1_rb_fff", 'hFFF, 8'hFF);
    readback("run1_rb_123", 'h123, 8'h23);
    img_read("run_wr_dropped", 5, img_m[5]);

    // One extra result overflows and leaves the buffer alone.
    cnn_valid_i = 1; cnn_data_i = 8'h77;
    tick();
    cnn_valid_i = 0;
    chk("ovf_set", overflow_o, 1'b1);
    chk("ovf_lat_frozen", latency_o, 21'd4097);
    readback("ovf_rb0", 0, 8'h00);
    tick(); tick();
    chk("done_hold", done_o, 1'b1);
    chk("ovf_sticky", overflow_o, 1'b1);

    // Reset in the middle of a run.
    start_run("run2");
    chk("run2_ovf_clr", overflow_o, 1'b0);
    captures(100, 1'b1, 1'b0, pulses);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_values();
    @(posedge clk); #3;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cnn_valid_i = 1; cnn_data_i = 8'hAA;
      tick();
      chk("post_rst_no_pulse", image_ready, 1'b0);
      chk("post_rst_idle_lat", latency_o, 21'd0);
    end
    cnn_valid_i = 0;
    img_read("mem_retained", 'h0A5, img_m['h0A5]);

    // Fresh run after the abort.
    start_run("run3");
    captures(OUTD, 1'b1, 1'b0, pulses);
    chk("run3_done", done_o, 1'b1);
    chk("run3_lat", latency_o, 21'd4097);
    chk("run3_ovf", overflow_o, 1'b0);
    readback("run3_rb0", 0, out_m[0]);
    readback("run3_rbfff", 'hFFF, out_m['hFFF]);
    for (int i = 0; i < 16; i++) begin
      a = int'($urandom_range(0, OUTD - 1));
      readback("run3_rb_rnd", a, out_m[a]);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
